// File: rtl/gate_sched_pkg.sv
// Shared types and the per-bit gate function for the gate-op scheduler.
package gate_sched_pkg;

  typedef enum logic {OP_AND = 1'b0, OP_OR = 1'b1} gate_op_t;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} out_state_t;

  function automatic logic gate_eval(gate_op_t op, logic a, logic b);
    return (op == OP_OR) ? (a | b) : (a & b);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
// gnt is gated by en; gnt_id names the winner even when en is low.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  always_comb begin
    logic found;
    int   idx;
    found  = 1'b0;
    idx    = 0;
    gnt    = '0;
    gnt_id = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt_id   = IDW'(idx);
        gnt[idx] = en;
      end
    end
  end

endmodule

// File: rtl/gate_op_scheduler.sv
// Shares one W-bit AND/OR unit among NREQ requesters, round-robin; 1-cycle registered result.
// A full, unaccepted result stalls all requesters; drain and refill can share an edge.
module gate_op_scheduler
  import gate_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_op,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic              resp_op,
  output logic [W-1:0]      resp_data
);

  out_state_t     state_q, state_d;
  logic [IDW-1:0] ptr;
  logic           can_accept;
  logic           fire;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0] gnt_id;
  logic [W-1:0]   sel_a, sel_b, result;
  gate_op_t       sel_op;

  assign can_accept = (state_q == EMPTY) || resp_ready;

  // nreset in the enable keeps every req_ready low while reset is held.
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req_valid),
    .ptr    (ptr),
    .en     (can_accept && nreset),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready = gnt;
  assign fire      = |gnt;

  assign sel_a  = req_a[int'(gnt_id)*W +: W];
  assign sel_b  = req_b[int'(gnt_id)*W +: W];
  assign sel_op = gate_op_t'(req_op[gnt_id]);

  always_comb begin
    result = '0;
    for (int i = 0; i < W; i++) begin
      result[i] = gate_eval(sel_op, sel_a[i], sel_b[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    if (fire) begin
      state_d = FULL;
    end else if (resp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ptr       <= '0;
      resp_id   <= '0;
      resp_op   <= 1'b0;
      resp_data <= '0;
    end else if (fire) begin
      ptr       <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
      resp_id   <= gnt_id;
      resp_op   <= sel_op;
      resp_data <= result;
    end
  end

  assign resp_valid = (state_q == FULL);

endmodule

// File: tb/tb_gate_op_scheduler.sv
// Directed bench for gate_op_scheduler (NREQ=4, W=8) with hand-computed expectations.
module tb_gate_op_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic              clk;
  logic              nreset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_op;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic              resp_op;
  logic [W-1:0]      resp_data;

  int checks = 0;
  int errors = 0;

  gate_op_scheduler #(.NREQ(NREQ), .W(W)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_op    (resp_op),
    .resp_data  (resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_resp(input string tag, input logic [31:0] id, input logic [31:0] op,
                            input logic [31:0] data);
    check({tag, "_valid"}, 32'(resp_valid), 32'h1);
    check({tag, "_id"},    32'(resp_id),    id);
    check({tag, "_op"},    32'(resp_op),    op);
    check({tag, "_data"},  32'(resp_data),  data);
  endtask

  // Requester table: r0 AND F0&3C=30, r1 OR 0F|A0=AF, r2 AND AA&0F=0A, r3 OR 11|44=55
  logic [1:0] exp_id   [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [7:0] exp_data [5] = '{8'hAF, 8'h0A, 8'h55, 8'h30, 8'hAF};
  logic       exp_op   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    nreset     = 1'b1;
    req_valid  = '0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    #1 nreset  = 1'b0;
    req_valid  = 4'b0001;
    req_op     = 4'b1010;
    req_a      = {8'h11, 8'hAA, 8'h0F, 8'hF0};
    req_b      = {8'h44, 8'h0F, 8'hA0, 8'h3C};
    resp_ready = 1'b1;
    #2;
    check("rst_valid", 32'(resp_valid), 32'h0);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_data",  32'(resp_data), 32'h0);
    check("rst_id",    32'(resp_id),   32'h0);

    // Single request after reset: 1-cycle latency, then drain to empty.
    repeat (2) @(posedge clk);
    #2 nreset = 1'b1;
    #1;
    check("t1_ready", 32'(req_ready), 32'h1);
    tick();
    check_resp("t1", 32'h0, 32'h0, 32'h30);
    req_valid = '0;
    tick();
    check("t1_drain_valid", 32'(resp_valid), 32'h0);

    // All valid, ptr=1: grants 1,2,3,0,1 with one response per cycle.
    req_valid = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      #1;
      check("t2_ready", 32'(req_ready), 32'(4'b0001 << exp_id[s]));
      tick();
      check_resp("t2", 32'(exp_id[s]), 32'(exp_op[s]), 32'(exp_data[s]));
    end

    // Backpressure: held result id1/AF, no requester granted.
    resp_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      check("t3_ready_stall", 32'(req_ready), 32'h0);
      tick();
      check_resp("t3_hold", 32'h1, 32'h1, 32'hAF);
    end
    resp_ready = 1'b1;
    #1;
    check("t3_ready_resume", 32'(req_ready), 32'h4);
    tick();
    check_resp("t3_resume", 32'h2, 32'h0, 32'h0A);

    // Same-edge drain and refill by r2 alone; boundary operands FF/00.
    req_valid = 4'b0100;
    req_op    = 4'b1110;
    req_a[23:16] = 8'hFF;
    req_b[23:16] = 8'h00;
    #1;
    check("t4_ready", 32'(req_ready), 32'h4);
    tick();
    check_resp("t4_or", 32'h2, 32'h1, 32'hFF);
    req_op = 4'b1010;
    #1;
    check("t4_ready2", 32'(req_ready), 32'h4);
    tick();
    check_resp("t4_and", 32'h2, 32'h0, 32'h00);

    // Mid-operation reset while full with requests pending.
    req_valid  = 4'b1111;
    resp_ready = 1'b0;
    #2 nreset  = 1'b0;
    #1;
    check("t5_rst_valid", 32'(resp_valid), 32'h0);
    check("t5_rst_ready", 32'(req_ready),  32'h0);
    check("t5_rst_data",  32'(resp_data),  32'h0);
    @(negedge clk);
    nreset     = 1'b1;
    req_valid  = 4'b1010;
    resp_ready = 1'b1;
    #1;
    check("t5_ready", 32'(req_ready), 32'h2);
    tick();
    check_resp("t5_first", 32'h1, 32'h1, 32'hAF);
    #1;
    check("t5_ready2", 32'(req_ready), 32'h8);
    tick();
    check_resp("t5_second", 32'h3, 32'h1, 32'h55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
